// File: rtl/voice_slot_sequencer.sv
// voice_slot_sequencer: per-sample sweep of voice/osc/env slots with drain, done pulse and overrun counting.
// Optional SEQ_PENDING_TICK_EN holds one early tick and restarts the next frame straight from DONE.
module voice_slot_sequencer #(
  parameter int VOICES       = 32,
  parameter int V_OSC        = 8,
  parameter int O_ENVS       = 2,
  parameter int V_WIDTH      = $clog2(VOICES),
  parameter int E_WIDTH      = $clog2(V_OSC) + 1,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                       sCLK_XVXENVS,
  input  logic                       reset,
  input  logic                       sample_tick,
  input  logic                       run_en,
  output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  output logic                       xxxx_zero,
  output logic                       slot_valid,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  output logic [7:0]                 overrun_cnt
);
  localparam int W  = V_WIDTH + E_WIDTH;
  localparam int N  = VOICES * V_OSC * O_ENVS;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [W-1:0]  LAST  = W'(N - 1);
  localparam logic [DW-1:0] DLOAD = DW'(DRAIN_CYCLES);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  xxxx_q, xxxx_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          zero_q, zero_d, valid_q, valid_d, busy_q, busy_d;
  logic          done_q, done_d, ovr_q, ovr_d, busy_now, pend_q, pend_d;
  always_comb begin
    state_d  = state_q;
    xxxx_d   = xxxx_q;
    drain_d  = drain_q;
    busy_now = state_q != IDLE;
`ifdef SEQ_PENDING_TICK_EN
    pend_d = pend_q | (sample_tick & busy_now);
    ovr_d  = sample_tick & busy_now & pend_q;
`else
    pend_d = 1'b0;
    ovr_d  = sample_tick & busy_now;
`endif
    case (state_q)
      IDLE: if (sample_tick & run_en) begin
        state_d = RUN;
        xxxx_d  = '0;
      end
      RUN: if (xxxx_q == LAST) begin
        state_d = DRAIN;
        xxxx_d  = '0;
        drain_d = DLOAD;
      end else xxxx_d = xxxx_q + 1'b1;
      DRAIN: if (drain_q == DW'(1)) state_d = DONE; else drain_d = drain_q - 1'b1;
      DONE: begin
        state_d = (pend_d & run_en) ? RUN : IDLE;
        xxxx_d  = '0;
        pend_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    zero_d  = state_d == RUN && xxxx_d == '0;
    valid_d = state_d == RUN;
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
    cnt_d   = (ovr_d && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge sCLK_XVXENVS or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      xxxx_q  <= '0;
      drain_q <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xxxx_q  <= xxxx_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      pend_q  <= pend_d;
    end
  end
  assign xxxx        = xxxx_q;
  assign xxxx_zero   = zero_q;
  assign slot_valid  = valid_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign overrun     = ovr_q;
  assign overrun_cnt = cnt_q;
endmodule
